chunk_deserializer: RTL
=======================

# chunk_deserializer

Parametrised successor to the team's chunk shift register. It accumulates `CHUNK_WIDTH`-bit chunks into a `REG_WIDTH`-chunk word and adds several features: selectable shift direction, an occupancy count, a valid/ready handshake on both sides, and a flush that emits partial words. It sits between a narrow chunk producer and a wide word consumer, and presents each completed word until the consumer accepts it.

## Interface
- `CHUNK_WIDTH`, default 8: bits per chunk.
- `REG_WIDTH`, default 4: chunks per word; must be at least 1.
- `SHIFT_DIR`, default 0:
  - 0: a new chunk enters at index `REG_WIDTH-1` and older chunks move toward index 0 (legacy order).
  - 1: a new chunk enters at index 0 and older chunks move toward index `REG_WIDTH-1`.
- `CNT_W`, default `$clog2(REG_WIDTH+1)`: width of `count_o`. Derived; do not override.

One clock; reset is asynchronous and active-low. Ports:
- `clk`, in, 1: rising-edge clock.
- `rst_n`, in, 1: asynchronous active-low reset.
- `data_i`, in, `CHUNK_WIDTH`: input chunk.
- `valid_i`, in, 1: input chunk valid.
- `ready_o`, out, 1: block can accept a chunk this cycle.
- `flush_i`, in, 1: close the current partial word.
- `data_o`, out, `[REG_WIDTH-1:0][CHUNK_WIDTH-1:0]`: word register, always visible.
- `count_o`, out, `CNT_W`: chunks currently held.
- `out_valid_o`, out, 1: word complete and presented.
- `out_ready_i`, in, 1: consumer accepts the word.

## Operation
- States: `FILL` and `HOLD`. In `HOLD`, `out_valid_o`=1; in `FILL`, `out_valid_o`=0.
- Reset values: state `FILL`, `data_o`=0, `count_o`=0, `out_valid_o`=0, `ready_o`=1.
- Reset is asynchronous. Asserting it mid-word discards the word immediately, with no emission.
- `ready_o` is combinational: `ready_o = (state==FILL) || out_ready_i`.
- A chunk is accepted on a rising edge when `valid_i && ready_o`. On acceptance:
  - The register shifts by one chunk per `SHIFT_DIR`; the chunk at the far end is discarded.
  - `count_o` increments by 1.
- Chunk placement for a partial word of k chunks:
  - `SHIFT_DIR`=0: the k chunks occupy indices `REG_WIDTH-1` down to `REG_WIDTH-k`.
  - `SHIFT_DIR`=1: the k chunks occupy indices `k-1` down to 0.
  - All remaining indices are zero.
- `FILL` to `HOLD` transition, at the edge where either:
  - the accepted chunk makes `count_o`=`REG_WIDTH`, or
  - `flush_i`=1 and the post-edge count is nonzero. A chunk accepted in the same cycle as the flush is included in the word.
- `flush_i` in `FILL` with `count_o`=0 and no accepted chunk: ignored.
- `flush_i` sampled while in `HOLD`: ignored, not queued.
- In `HOLD`, `data_o` and `count_o` are stable until the consumer accepts.
- On an edge in `HOLD` with `out_ready_i`=1:
  - No input chunk: the register clears to 0, `count_o`=0, next state `FILL`.
  - `valid_i`=1 (pass-through): the register clears and the new chunk loads as the first chunk, giving `count_o`=1. Next state is `FILL`, or `HOLD` if `REG_WIDTH`=1 or `flush_i`=1.
- `HOLD` with `out_ready_i`=0: `ready_o`=0 and input is stalled. The producer must hold `data_i` and `valid_i` stable.
- `count_o` never exceeds `REG_WIDTH`. The count and word register have no wrap-around.

## Timing
- All outputs are registered except `ready_o`, which is combinational from state and `out_ready_i`.
- A chunk accepted at edge N is visible on `data_o` and `count_o` immediately after edge N.
- `out_valid_o` rises immediately after the edge that accepts the last chunk, or after the flush edge. There is no extra cycle.
- The word is consumed at the edge where `out_valid_o && out_ready_i`.
- Throughput with `out_ready_i` held at 1 and `valid_i` continuous: one word every `REG_WIDTH` cycles, with no bubbles.
- `REG_WIDTH`=1: every accepted chunk goes directly to `HOLD`, and `count_o` toggles between 0 and 1.

## Test plan
1. Reset: drive `rst_n`=0 asynchronously mid-word (after chunks 11, 22). Required response:
   - Without waiting for a clock edge: `data_o`=0, `count_o`=0, `out_valid_o`=0.
   - After release: `ready_o`=1.
2. Legacy order, `SHIFT_DIR`=0 with 8/4: accept ff. Required: `data_o`=0xff000000, `count_o`=1, `out_valid_o`=0.
3. Full and stall, `SHIFT_DIR`=0, `out_ready_i`=0: accept 11, 22, 33, 44. Required:
   - `data_o`=0x44332211, `count_o`=4, `out_valid_o`=1, `ready_o`=0.
   - Offering 55 for 3 cycles leaves the word unchanged.
4. Pass-through, continuing from scenario 3: raise `out_ready_i` with 55 still valid. Required: after the edge, `data_o`=0x55000000, `count_o`=1, `out_valid_o`=0.
5. Flush, `SHIFT_DIR`=0: accept aa, bb, then pulse `flush_i`. Required:
   - `out_valid_o`=1, `count_o`=2, `data_o`=0xbbaa0000.
   - After the word is consumed, a second `flush_i` with `count_o`=0 leaves `out_valid_o`=0.
6. Reverse order, `SHIFT_DIR`=1: accept 11, 22, 33, 44. Required:
   - `data_o`=0x11223344, `out_valid_o`=1.
   - Partial flush after 11, 22 gives `data_o`=0x00001122.

Source files
------------

// File: rtl/chunk_deserializer.sv
// Collects CHUNK_WIDTH-bit chunks into a REG_WIDTH-chunk word and presents it
// over a valid/ready handshake. A flush closes a partially filled word early.
module chunk_deserializer #(
    parameter int CHUNK_WIDTH = 8,
    parameter int REG_WIDTH   = 4,
    parameter int SHIFT_DIR   = 0,
    parameter int CNT_W       = $clog2(REG_WIDTH + 1)
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic [CHUNK_WIDTH-1:0]                data_i,
    input  logic                                  valid_i,
    output logic                                  ready_o,
    input  logic                                  flush_i,
    output logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] data_o,
    output logic [CNT_W-1:0]                      count_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i
);

    // state | meaning
    // FILL  | collecting chunks, word not yet presented
    // HOLD  | word complete (or flushed) and presented until consumed
    typedef enum logic {FILL, HOLD} state_t;

    state_t                                state;
    logic                                  accept;
    logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] base_word;
    logic [REG_WIDTH-1:0][CHUNK_WIDTH-1:0] shifted_word;
    logic [CNT_W-1:0]                      base_cnt;
    logic [CNT_W-1:0]                      next_cnt;
    logic                                  close_word;

    assign ready_o = (state == FILL) || out_ready_i;
    assign accept  = valid_i && ready_o;

    // A chunk accepted while in HOLD starts a fresh word, so shift into zero.
    always_comb begin
        base_word    = (state == HOLD) ? '0 : data_o;
        base_cnt     = (state == HOLD) ? '0 : count_o;
        next_cnt     = base_cnt + CNT_W'(1);
        close_word   = (next_cnt == CNT_W'(REG_WIDTH)) || flush_i;
        shifted_word = '0;
        if (SHIFT_DIR == 0) begin
            for (int i = 0; i < REG_WIDTH - 1; i++) shifted_word[i] = base_word[i+1];
            shifted_word[REG_WIDTH-1] = data_i;
        end else begin
            for (int i = 1; i < REG_WIDTH; i++) shifted_word[i] = base_word[i-1];
            shifted_word[0] = data_i;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= FILL;
            data_o      <= '0;
            count_o     <= '0;
            out_valid_o <= 1'b0;
        end else begin
            case (state)
                FILL: begin
                    if (accept) begin
                        data_o  <= shifted_word;
                        count_o <= next_cnt;
                        if (close_word) begin
                            state       <= HOLD;
                            out_valid_o <= 1'b1;
                        end
                    end else if (flush_i && (count_o != '0)) begin
                        state       <= HOLD;
                        out_valid_o <= 1'b1;
                    end
                end
                HOLD: begin
                    if (out_ready_i) begin
                        if (valid_i) begin
                            data_o  <= shifted_word;
                            count_o <= next_cnt;
                            if (!close_word) begin
                                state       <= FILL;
                                out_valid_o <= 1'b0;
                            end
                        end else begin
                            data_o      <= '0;
                            count_o     <= '0;
                            state       <= FILL;
                            out_valid_o <= 1'b0;
                        end
                    end
                end
                default: begin
                    state       <= FILL;
                    out_valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
